// File: rtl/riscv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_mem_arbiter
//
// Shares one line-wide backing memory port between the instruction-cache
// refill FSM (read only) and the data-cache refill/writeback FSM (read/write).
// Round-robin between the two sides, one transaction in flight at a time.
// A grant is held until the memory returns its ready pulse.
//
// Optional feature macro: RISCV_MEMARB_TIMEOUT_EN
//   When defined, a 16-bit watchdog aborts a grant that has waited
//   TIMEOUT_CYCLES cycles. The abort pulses the granted side's ready with zero
//   data and sets a sticky timeout flag. When undefined, a grant waits forever
//   and the timeout output is tied low.
//
// Parameters:
//   DATA_WIDTH      cache line width in bits
//   S_ADDR          line address width
//   TIMEOUT_CYCLES  watchdog limit (used only with RISCV_MEMARB_TIMEOUT_EN)
//
// Ports:
//   i_riscv_memarb_clk            clock
//   i_riscv_memarb_rst_n          asynchronous active-low reset
//   i_riscv_memarb_imem_rden      icache line read request (held until ready)
//   i_riscv_memarb_imem_addr      icache line address
//   o_riscv_memarb_imem_ready     one-cycle completion pulse to icache
//   o_riscv_memarb_imem_data_out  read line to icache
//   i_riscv_memarb_dmem_rden      dcache line read request
//   i_riscv_memarb_dmem_wren      dcache line write request
//   i_riscv_memarb_dmem_addr      dcache line address
//   i_riscv_memarb_dmem_data_in   dcache writeback line
//   o_riscv_memarb_dmem_ready     one-cycle completion pulse to dcache
//   o_riscv_memarb_dmem_data_out  read line to dcache
//   o_riscv_memarb_mem_rden       read strobe to RAM
//   o_riscv_memarb_mem_wren       write strobe to RAM
//   o_riscv_memarb_mem_addr       line address to RAM
//   o_riscv_memarb_mem_data_in    write line to RAM
//   i_riscv_memarb_mem_data_out   read line from RAM
//   i_riscv_memarb_mem_ready      completion pulse from RAM
//   o_riscv_memarb_busy           high while a grant is active
//   o_riscv_memarb_timeout        sticky watchdog flag
// -----------------------------------------------------------------------------
module riscv_mem_arbiter #(
    parameter int DATA_WIDTH     = 128,
    parameter int S_ADDR         = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_riscv_memarb_clk,
    input  logic                  i_riscv_memarb_rst_n,
    input  logic                  i_riscv_memarb_imem_rden,
    input  logic [S_ADDR-1:0]     i_riscv_memarb_imem_addr,
    output logic                  o_riscv_memarb_imem_ready,
    output logic [DATA_WIDTH-1:0] o_riscv_memarb_imem_data_out,
    input  logic                  i_riscv_memarb_dmem_rden,
    input  logic                  i_riscv_memarb_dmem_wren,
    input  logic [S_ADDR-1:0]     i_riscv_memarb_dmem_addr,
    input  logic [DATA_WIDTH-1:0] i_riscv_memarb_dmem_data_in,
    output logic                  o_riscv_memarb_dmem_ready,
    output logic [DATA_WIDTH-1:0] o_riscv_memarb_dmem_data_out,
    output logic                  o_riscv_memarb_mem_rden,
    output logic                  o_riscv_memarb_mem_wren,
    output logic [S_ADDR-1:0]     o_riscv_memarb_mem_addr,
    output logic [DATA_WIDTH-1:0] o_riscv_memarb_mem_data_in,
    input  logic [DATA_WIDTH-1:0] i_riscv_memarb_mem_data_out,
    input  logic                  i_riscv_memarb_mem_ready,
    output logic                  o_riscv_memarb_busy,
    output logic                  o_riscv_memarb_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    lastGrantD_q, lastGrantD_d;
    logic [S_ADDR-1:0]       addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    rden_q, rden_d;
    logic                    wren_q, wren_d;

    logic reqI;
    logic reqD;
    logic pickI;
    logic inGrant;
    logic forceEnd;
    logic grantEnd;

    assign reqI    = i_riscv_memarb_imem_rden;
    assign reqD    = i_riscv_memarb_dmem_rden | i_riscv_memarb_dmem_wren;
    assign inGrant = (state_q != IDLE);

    // On a tie the side that did not win last time gets the grant. Reset
    // leaves lastGrantD_q set, so the first tie goes to the instruction side.
    assign pickI = reqI & (~reqD | lastGrantD_q);

    // A grant ends on the memory's ready pulse or on a watchdog abort.
    assign grantEnd = i_riscv_memarb_mem_ready | forceEnd;

`ifdef RISCV_MEMARB_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] toCnt_q, toCnt_d;
    logic        timeout_q, timeout_d;

    // The counter sits at zero in IDLE, so the first grant cycle sees 0 and
    // grant cycle N sees N-1; the abort therefore lands on grant cycle
    // TIMEOUT_CYCLES. A real ready in that same cycle takes precedence.
    assign forceEnd = inGrant & ~i_riscv_memarb_mem_ready & (toCnt_q == TimeoutLast);

    // Watchdog next-state: count grant cycles, latch the flag on any abort.
    always_comb begin
        toCnt_d   = '0;
        timeout_d = timeout_q;
        if (inGrant) begin
            toCnt_d = toCnt_q + 16'd1;
        end
        if (forceEnd) begin
            timeout_d = 1'b1;
        end
    end

    // Watchdog registers; the flag only clears through reset.
    always_ff @(posedge i_riscv_memarb_clk or negedge i_riscv_memarb_rst_n) begin
        if (!i_riscv_memarb_rst_n) begin
            toCnt_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            toCnt_q   <= toCnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_riscv_memarb_timeout = timeout_q;
`else
    logic unusedTimeoutCfg;

    assign unusedTimeoutCfg       = (TIMEOUT_CYCLES != 0);
    assign forceEnd               = 1'b0;
    assign o_riscv_memarb_timeout = 1'b0;
`endif

    // Next-state logic. The request is captured on grant entry so the RAM
    // sees stable strobes, address and data for the whole grant even if the
    // requester changes or drops its inputs. A simultaneous dcache read and
    // write is illegal; the write is forwarded and the read dropped.
    always_comb begin
        state_d      = state_q;
        lastGrantD_d = lastGrantD_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rden_d       = rden_q;
        wren_d       = wren_q;
        case (state_q)
            IDLE: begin
                if (reqI || reqD) begin
                    if (pickI) begin
                        state_d = GNT_I;
                        addr_d  = i_riscv_memarb_imem_addr;
                        rden_d  = 1'b1;
                        wren_d  = 1'b0;
                    end else begin
                        state_d = GNT_D;
                        addr_d  = i_riscv_memarb_dmem_addr;
                        wdata_d = i_riscv_memarb_dmem_data_in;
                        wren_d  = i_riscv_memarb_dmem_wren;
                        rden_d  = i_riscv_memarb_dmem_rden & ~i_riscv_memarb_dmem_wren;
                    end
                end
            end
            GNT_I, GNT_D: begin
                if (grantEnd) begin
                    state_d      = IDLE;
                    lastGrantD_d = (state_q == GNT_D);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge i_riscv_memarb_clk or negedge i_riscv_memarb_rst_n) begin
        if (!i_riscv_memarb_rst_n) begin
            state_q      <= IDLE;
            lastGrantD_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            rden_q       <= 1'b0;
            wren_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lastGrantD_q <= lastGrantD_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rden_q       <= rden_d;
            wren_q       <= wren_d;
        end
    end

    // Strobes are gated by the grant state, so they fall the cycle after
    // ready and immediately on an asynchronous reset.
    assign o_riscv_memarb_busy        = inGrant;
    assign o_riscv_memarb_mem_rden    = inGrant & rden_q;
    assign o_riscv_memarb_mem_wren    = inGrant & wren_q;
    assign o_riscv_memarb_mem_addr    = addr_q;
    assign o_riscv_memarb_mem_data_in = wdata_q;

    // Only the granted side ever sees ready; data is broadcast and is zeroed
    // on a watchdog abort so a stale line is never mistaken for a refill.
    assign o_riscv_memarb_imem_ready    = (state_q == GNT_I) & grantEnd;
    assign o_riscv_memarb_dmem_ready    = (state_q == GNT_D) & grantEnd;
    assign o_riscv_memarb_imem_data_out = forceEnd ? '0 : i_riscv_memarb_mem_data_out;
    assign o_riscv_memarb_dmem_data_out = forceEnd ? '0 : i_riscv_memarb_mem_data_out;

    // A simultaneous dcache read and write request is illegal stimulus.
    illegalDmemRdWr: assert property (
        @(posedge i_riscv_memarb_clk) disable iff (!i_riscv_memarb_rst_n)
        !(i_riscv_memarb_dmem_rden && i_riscv_memarb_dmem_wren)
    );

endmodule
